// File: rtl/decoded_inst_queue_if.sv
// Decode-to-issue bundle for the decoded instruction queue.
// Slave is the queue side; master is the decode/issue side.
interface decoded_inst_queue_if #(
   parameter int OPCODE_W   = 6,
   parameter int TYPE_W     = 4,
   parameter int REG_ADDR_W = 5,
   parameter int IMM_W      = 16,
   parameter int VALUE_W    = 32,
   parameter int PC_W       = 32,
   parameter int DEPTH      = 4
);
   localparam int WORD_W = 6 + OPCODE_W + TYPE_W + 3 * REG_ADDR_W
                         + IMM_W + VALUE_W + PC_W;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic                  use_rs1;
   logic                  use_rs2;
   logic                  use_rd;
   logic                  use_imm;
   logic                  read_mem;
   logic                  write_mem;
   logic [OPCODE_W-1:0]   decoded_opcode;
   logic [TYPE_W-1:0]     inst_type;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [IMM_W-1:0]      imm;
   logic [VALUE_W-1:0]    value;
   logic [PC_W-1:0]       npc;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [WORD_W-1:0]     out_word;
   logic [CNT_W-1:0]      count;

   modport slave (
      input  in_valid, use_rs1, use_rs2, use_rd, use_imm,
      input  read_mem, write_mem, decoded_opcode, inst_type,
      input  rs1_addr, rs2_addr, rd_addr, imm, value, npc,
      input  flush, out_ready,
      output in_ready, out_valid, out_word, count
   );

   modport master (
      output in_valid, use_rs1, use_rs2, use_rd, use_imm,
      output read_mem, write_mem, decoded_opcode, inst_type,
      output rs1_addr, rs2_addr, rd_addr, imm, value, npc,
      output flush, out_ready,
      input  in_ready, out_valid, out_word, count
   );
endinterface

// File: rtl/decoded_inst_queue.sv
// Packs decoded fields into one word and buffers them in order
// between decode and issue; flush drops everything for redirects.
module decoded_inst_queue #(
   parameter int OPCODE_W   = 6,
   parameter int TYPE_W     = 4,
   parameter int REG_ADDR_W = 5,
   parameter int IMM_W      = 16,
   parameter int VALUE_W    = 32,
   parameter int PC_W       = 32,
   parameter int DEPTH      = 4
) (
   input logic                clk,
   input logic                rst,
   decoded_inst_queue_if.slave bus
);
   localparam int WORD_W = 6 + OPCODE_W + TYPE_W + 3 * REG_ADDR_W
                         + IMM_W + VALUE_W + PC_W;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] word;
   logic              push;
   logic              pop;

   assign word = {bus.npc, bus.value, bus.imm,
                  bus.rd_addr, bus.rs2_addr, bus.rs1_addr,
                  bus.inst_type, bus.decoded_opcode,
                  bus.write_mem, bus.read_mem, bus.use_imm,
                  bus.use_rd, bus.use_rs2, bus.use_rs1};

   // in_ready looks only at registered state, never at out_ready
   assign bus.in_ready  = !rst && (cnt_q < FULL);
   assign bus.out_valid = (cnt_q != '0);
   assign bus.out_word  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.count     = cnt_q;

   assign push = bus.in_valid && bus.in_ready && !bus.flush;
   assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // storage is left uncleared; only pointers and count reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= word;
   end
endmodule

// File: doc/decoded_inst_queue.md
Name: decoded_inst_queue

Overview:
Parametrised decode-stage output block. It packs the decoded instruction fields into one decoded-instruction word and buffers up to DEPTH words in an in-order queue. The queue sits between decode and issue, with valid/ready handshakes on both sides and a flush input for branch redirects. Field widths, queue depth and flag layout are set by parameters.

Parameters:
OPCODE_W, 6, decoded opcode width
TYPE_W, 4, instruction-type signal width
REG_ADDR_W, 5, register address width (rs1/rs2/rd)
IMM_W, 16, immediate width
VALUE_W, 32, value field width
PC_W, 32, next-PC width
DEPTH, 4, queue entries; power of two, >= 2
WORD_W, 6+OPCODE_W+TYPE_W+3*REG_ADDR_W+IMM_W+VALUE_W+PC_W (111), derived; must not be overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  decode presents an instruction
in_ready  out  1  queue accepts this cycle
use_rs1, use_rs2, use_rd, use_imm, read_mem, write_mem  in  1 each  decode flags
decoded_opcode  in  OPCODE_W  opcode
inst_type  in  TYPE_W  type signal
rs1_addr, rs2_addr, rd_addr  in  REG_ADDR_W each  register addresses
imm  in  IMM_W  immediate
value  in  VALUE_W  value
npc  in  PC_W  next PC
flush  in  1  discard all queued and incoming entries
out_valid  out  1  head entry valid
out_ready  in  1  issue consumes head
out_word  out  WORD_W  packed head entry
count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Packing, LSB first: bit0 use_rs1, bit1 use_rs2, bit2 use_rd, bit3 use_imm, bit4 read_mem, bit5 write_mem, then decoded_opcode, inst_type, rs1_addr, rs2_addr, rd_addr, imm, value, npc (npc in the top PC_W bits). Fields are contiguous, with no padding.
- Push: a push occurs when in_valid && in_ready && !flush. Pop: a pop occurs when out_valid && out_ready && !flush.
- in_ready = !rst && (count < DEPTH). It depends only on registered state, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_word = storage[rd_ptr] when out_valid, and all-zero otherwise.
- Latency: there is no fall-through. A word pushed into an empty queue in cycle N is presented with out_valid high in cycle N+1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1. When full, in_ready is low, so a push is impossible even if a pop occurs.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register.
- flush has priority over push and pop. The next cycle has rd_ptr = wr_ptr = 0, count = 0 and out_valid = 0. The concurrent input is dropped. Storage RAM is not cleared.
- Reset values: count = 0, pointers = 0, out_valid = 0, out_word = 0, in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset mid-operation discards all entries, exactly like flush. rst overrides flush.
- Inputs are sampled only on a push. Field values are don't-care otherwise.

Test Plan:
- Pack check: push one entry with flags = 6'b101011, opcode = 6'h2A, type = 4'h5, rs1 = 1, rs2 = 2, rd = 31, imm = 16'hBEEF, value = 32'h12345678, npc = 32'h00000104 -> next cycle out_valid = 1 and out_word = the exact concatenation in the layout above; bits [5:0] = 6'b101011 and bits [110:79] = 32'h00000104.
- Fill/full: hold out_ready = 0 and push 4 entries (npc = 4, 8, 12, 16) -> count = 4, in_ready = 0, and a 5th in_valid is not accepted. Then set out_ready = 1 -> npc pops in order 4, 8, 12, 16, then out_valid = 0.
- Simultaneous push and pop at count = 2 for 10 cycles with incrementing npc -> count stays 2, order is preserved, and pointers wrap without loss.
- Flush with in_valid = 1 at count = 3 -> next cycle count = 0, out_valid = 0 and out_word = 0. The flushed-cycle input never appears. A push on the following cycle appears as the head one cycle later.
- Reset mid-stream at count = 2 -> during rst, in_ready = 0. After rst deasserts, count = 0 and out_valid = 0, and the next push behaves normally.
- Parameter sweep DEPTH = 2 and DEPTH = 8 with VALUE_W = 64 -> WORD_W matches the formula, full asserts at exactly DEPTH, and ordering is correct.
